// File: rtl/gradient_job_scheduler_pkg.sv
// rtl/gradient_job_scheduler_pkg.sv - shared widths, FSM state type and helpers for the gradient job scheduler
package gradient_job_scheduler_pkg;

  localparam int PIX_W       = 24;
  localparam int WIN_W       = 9 * PIX_W;
  localparam int DEF_TIMEOUT = 1023;
  localparam int CYC_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic [CYC_W-1:0] sat_cycles(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? {CYC_W{1'b1}} : v[CYC_W-1:0];
  endfunction

endpackage

// File: rtl/gradient_job_scheduler_if.sv
// rtl/gradient_job_scheduler_if.sv - requester, engine and response signal bundle of the scheduler
interface gradient_job_scheduler_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  import gradient_job_scheduler_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIN_W-1:0] req_a;
  logic [NREQ-1:0]       req_ready;

  logic                  eng_rst;
  logic                  eng_en;
  logic [WIN_W-1:0]      eng_a;
  logic [WIN_W-1:0]      eng_gm;
  logic                  eng_done;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIN_W-1:0]      rsp_gm;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;

  logic                  busy;
  logic [CYC_W-1:0]      job_cycles;

  // Scheduler side
  modport slave (
    input  req_valid, req_a, eng_gm, eng_done, rsp_ready,
    output req_ready, eng_rst, eng_en, eng_a, rsp_valid, rsp_gm, rsp_id, rsp_err, busy, job_cycles
  );

  // Producers, engine and consumer side
  modport master (
    output req_valid, req_a, eng_gm, eng_done, rsp_ready,
    input  req_ready, eng_rst, eng_en, eng_a, rsp_valid, rsp_gm, rsp_id, rsp_err, busy, job_cycles
  );

endinterface

// File: rtl/gradient_job_scheduler_arbiter.sv
// rtl/gradient_job_scheduler_arbiter.sv - combinational round-robin pick of the first valid requester after ptr
module gm_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  // Search starts one past the last winner so the previous grantee goes last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/gradient_job_scheduler.sv
// rtl/gradient_job_scheduler.sv - shares one gradient/magnitude engine among NREQ window producers
module gradient_job_scheduler
  import gradient_job_scheduler_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     Clock,
  input  logic                     reset,
  gradient_job_scheduler_if.slave  bus
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;

  logic [WIN_W-1:0] eng_a_q;
  logic             eng_en_q;
  logic             eng_rst_q;
  logic [WIN_W-1:0] rsp_gm_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_err_q;
  logic             rsp_valid_q;
  logic [31:0]      run_cnt;
  logic [CYC_W-1:0] job_cycles_q;

  gm_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= IDW'(NREQ - 1);
      eng_a_q      <= '0;
      eng_en_q     <= 1'b0;
      eng_rst_q    <= 1'b0;
      rsp_gm_q     <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      run_cnt      <= '0;
      job_cycles_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            eng_a_q   <= bus.req_a[int'(grant_idx) * WIN_W +: WIN_W];
            rsp_id_q  <= grant_idx;
            rr_ptr    <= grant_idx;
            eng_rst_q <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // One-cycle engine reset also wipes a done flag left from the last job.
          eng_rst_q <= 1'b0;
          eng_en_q  <= 1'b1;
          run_cnt   <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (bus.eng_done) begin
            rsp_gm_q     <= bus.eng_gm;
            rsp_err_q    <= 1'b0;
            eng_en_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            job_cycles_q <= sat_cycles(run_cnt);
            state        <= RESP;
          end else if (run_cnt == 32'(TIMEOUT - 1)) begin
            rsp_gm_q     <= '0;
            rsp_err_q    <= 1'b1;
            eng_en_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            job_cycles_q <= sat_cycles(run_cnt);
            state        <= RESP;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Engine reset is forced while the scheduler itself is held in reset.
  assign bus.eng_rst    = eng_rst_q | ~reset;
  assign bus.req_ready  = (state == IDLE && reset) ? grant : '0;
  assign bus.eng_en     = eng_en_q;
  assign bus.eng_a      = eng_a_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_gm     = rsp_gm_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state != IDLE);
  assign bus.job_cycles = job_cycles_q;

endmodule

// File: tb/tb_gradient_job_scheduler.sv
// tb/tb_gradient_job_scheduler.sv - directed self-checking bench with a counting engine stub
module tb_gradient_job_scheduler;
  import gradient_job_scheduler_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int TO   = 1023;

  localparam logic [WIN_W-1:0] W0 = {27{8'hC3}};
  localparam logic [WIN_W-1:0] W1 = {27{8'h3C}};
  localparam logic [WIN_W-1:0] GA = {27{8'hA5}};
  localparam logic [WIN_W-1:0] GB = {27{8'h5E}};

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gradient_job_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) ifc ();

  gradient_job_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
    .Clock (clk),
    .reset (rstn),
    .bus   (ifc)
  );

  // Engine stub: done once D enabled cycles have elapsed since its last reset.
  int               stub_d     = 165;
  logic             stub_never = 1'b0;
  int               stub_cnt;
  logic [WIN_W-1:0] stub_gm    = GA;

  always @(posedge clk) begin
    if (ifc.eng_rst) stub_cnt <= 0;
    else if (ifc.eng_en) stub_cnt <= stub_cnt + 1;
  end
  assign ifc.eng_done = !stub_never && (stub_cnt >= stub_d);
  assign ifc.eng_gm   = stub_gm;

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  // Runs one job from the IDLE grant to the response handshake; starts and ends just after a posedge.
  task automatic do_job(input string nm, input logic [1:0] valid, input logic hold, input int exp_g,
                        input logic exp_err, input logic [WIN_W-1:0] exp_gm, input int exp_cyc,
                        input int stall);
    int n_rst, n_en, n_rdy, t;
    logic [WIN_W-1:0] a_seen, exp_a;
    exp_a = (exp_g == 0) ? W0 : W1;
    a_seen = '0;
    ifc.req_valid = valid;
    ifc.req_a     = {W1, W0};
    #2;
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL %s idle_busy: got %b want 0", nm, ifc.busy); end
    total++; if (ifc.req_ready !== (2'b01 << exp_g)) begin bad++; $display("FAIL %s grant: got %b want %b", nm, ifc.req_ready, 2'b01 << exp_g); end
    @(posedge clk); #1;
    if (!hold) begin
      ifc.req_valid = '0;
      ifc.req_a     = '0;
    end
    n_rst = 0; n_en = 0; n_rdy = 0; t = 0;
    while (ifc.rsp_valid !== 1'b1 && t < 1200) begin
      @(negedge clk);
      t++;
      if (ifc.eng_rst === 1'b1) n_rst++;
      if (ifc.eng_en === 1'b1) begin
        n_en++;
        if (n_en == 1) a_seen = ifc.eng_a;
      end
      if (|ifc.req_ready) n_rdy++;
    end
    total++; if (t >= 1200) begin bad++; $display("FAIL %s rsp_timeout: got %0d cycles want <1200", nm, t); end
    total++; if (n_rst != 1) begin bad++; $display("FAIL %s eng_rst_cycles: got %0d want 1", nm, n_rst); end
    total++; if (n_en != exp_cyc + 1) begin bad++; $display("FAIL %s eng_en_cycles: got %0d want %0d", nm, n_en, exp_cyc + 1); end
    total++; if (n_rdy != 0) begin bad++; $display("FAIL %s extra_ready: got %0d want 0", nm, n_rdy); end
    total++; if (a_seen !== exp_a) begin bad++; $display("FAIL %s eng_a: got %h want %h", nm, a_seen, exp_a); end
    total++; if (ifc.rsp_id !== IDW'(exp_g)) begin bad++; $display("FAIL %s rsp_id: got %0d want %0d", nm, ifc.rsp_id, exp_g); end
    total++; if (ifc.rsp_err !== exp_err) begin bad++; $display("FAIL %s rsp_err: got %b want %b", nm, ifc.rsp_err, exp_err); end
    total++; if (ifc.rsp_gm !== exp_gm) begin bad++; $display("FAIL %s rsp_gm: got %h want %h", nm, ifc.rsp_gm, exp_gm); end
    total++; if (ifc.job_cycles !== 16'(exp_cyc)) begin bad++; $display("FAIL %s job_cycles: got %0d want %0d", nm, ifc.job_cycles, exp_cyc); end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      total++;
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_gm !== exp_gm || ifc.rsp_id !== IDW'(exp_g) ||
          ifc.rsp_err !== exp_err || ifc.eng_en !== 1'b0 || ifc.req_ready !== 2'b00) begin
        bad++;
        $display("FAIL %s stall_hold[%0d]: got v=%b id=%0d err=%b en=%b rdy=%b want v=1 id=%0d err=%b en=0 rdy=0",
                 nm, i, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.eng_en, ifc.req_ready, exp_g, exp_err);
      end
    end
    ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    total++; if (ifc.rsp_valid !== 1'b0) begin bad++; $display("FAIL %s rsp_drop: got %b want 0", nm, ifc.rsp_valid); end
  endtask

  task automatic test_reset();
    ifc.req_valid = 2'b11;
    ifc.req_a     = {W1, W0};
    ifc.rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (ifc.eng_rst !== 1'b1) begin bad++; $display("FAIL reset eng_rst: got %b want 1", ifc.eng_rst); end
    total++; if (ifc.req_ready !== 2'b00) begin bad++; $display("FAIL reset req_ready: got %b want 00", ifc.req_ready); end
    total++;
    if (ifc.busy !== 1'b0 || ifc.eng_en !== 1'b0 || ifc.rsp_valid !== 1'b0 || ifc.rsp_err !== 1'b0 ||
        ifc.rsp_id !== '0 || ifc.job_cycles !== '0 || ifc.rsp_gm !== '0 || ifc.eng_a !== '0) begin
      bad++;
      $display("FAIL reset outputs: got busy=%b en=%b v=%b err=%b id=%0d cyc=%0d want all 0",
               ifc.busy, ifc.eng_en, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_id, ifc.job_cycles);
    end
    ifc.req_valid = 2'b00;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    stub_d = 165; stub_never = 1'b0; stub_gm = GA;
    do_job("single", 2'b01, 1'b0, 0, 1'b0, GA, 165, 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    stub_d = 5; stub_gm = GB;
    do_job("rr0", 2'b11, 1'b1, 0, 1'b0, GB, 5, 0);
    do_job("rr1", 2'b11, 1'b1, 1, 1'b0, GB, 5, 0);
    do_job("rr2", 2'b11, 1'b1, 0, 1'b0, GB, 5, 0);
    do_job("rr3", 2'b11, 1'b1, 1, 1'b0, GB, 5, 0);
    ifc.req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    stub_never = 1'b1; stub_gm = GA;
    do_job("timeout", 2'b01, 1'b0, 0, 1'b1, '0, TO - 1, 0);
    stub_never = 1'b0; stub_d = 7; stub_gm = GB;
    do_job("after_to", 2'b10, 1'b0, 1, 1'b0, GB, 7, 0);
  endtask

  task automatic test_stall();
    stub_d = 3; stub_gm = GA;
    do_job("stall", 2'b01, 1'b0, 0, 1'b0, GA, 3, 20);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    stub_d = 100; stub_gm = GB;
    ifc.req_valid = 2'b01;
    ifc.req_a     = {W1, W0};
    @(posedge clk); #1;
    ifc.req_valid = 2'b00;
    repeat (10) @(negedge clk);
    total++; if (ifc.eng_en !== 1'b1) begin bad++; $display("FAIL midrst in_run: got %b want 1", ifc.eng_en); end
    rstn = 1'b0;
    #1;
    total++; if (ifc.eng_rst !== 1'b1) begin bad++; $display("FAIL midrst eng_rst: got %b want 1", ifc.eng_rst); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (ifc.busy !== 1'b0 || ifc.eng_en !== 1'b0 || ifc.eng_rst !== 1'b0 || ifc.rsp_valid !== 1'b0 ||
        ifc.job_cycles !== '0 || ifc.rsp_gm !== '0 || ifc.eng_a !== '0) begin
      bad++;
      $display("FAIL midrst outputs: got busy=%b en=%b rst=%b v=%b cyc=%0d want all 0",
               ifc.busy, ifc.eng_en, ifc.eng_rst, ifc.rsp_valid, ifc.job_cycles);
    end
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (ifc.rsp_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst no_rsp: got %0d want 0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_done_vs_timeout();
    stub_never = 1'b0; stub_d = TO - 1; stub_gm = GA;
    do_job("tie", 2'b11, 1'b0, 0, 1'b0, GA, TO - 1, 0);
  endtask

  initial begin
    ifc.req_valid = '0;
    ifc.req_a     = '0;
    ifc.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stall();
    test_reset_mid_run();
    test_done_vs_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
